// File: rtl/pc_fetch_unit.sv
// PC + fetch stage: holds pc, fetches over req/ack, presents instr,
// resolves next pc from branch type, offset, jr value and latched flags.
//
// Ports:
//   clk, rst          clock, sync active-high reset
//   imem_req/addr     fetch request and address (= pc)
//   imem_ack/rdata    fetch response
//   instr/instr_valid registered instruction, valid during EXEC
//   pc/npc            current pc and pc+4 (link value)
//   exec_done         datapath done; branch inputs and flags valid
//   br_type/br_offset branch kind and signed byte offset from npc
//   jr_target         register value for JR
//   flag_we, *_flag   latch live ALU flags at exec_done
//   halt/halted       stop fetching; halted state indication
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          OFF_W    = 26
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [31:0]      pc,
  output logic [31:0]      npc,
  input  logic             exec_done,
  input  logic [3:0]       br_type,
  input  logic [OFF_W-1:0] br_offset,
  input  logic [31:0]      jr_target,
  input  logic             flag_we,
  input  logic             zero_flag,
  input  logic             carry_flag,
  input  logic             sign_flag,
  input  logic             overflow_flag,
  input  logic             halt,
  output logic             halted
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    HALTED
  } state_t;

  localparam logic [3:0] BR_SEQ  = 4'd0;
  localparam logic [3:0] BR_B    = 4'd1;
  localparam logic [3:0] BR_BL   = 4'd2;
  localparam logic [3:0] BR_JR   = 4'd3;
  localparam logic [3:0] BR_BZ   = 4'd4;
  localparam logic [3:0] BR_BNZ  = 4'd5;
  localparam logic [3:0] BR_BCY  = 4'd6;
  localparam logic [3:0] BR_BNCY = 4'd7;
  localparam logic [3:0] BR_BLTZ = 4'd8;
  localparam logic [3:0] BR_BOV  = 4'd9;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  flags;
  logic        fz;
  logic        fc;
  logic        fs;
  logic        fv;
  logic [31:0] off_sext;
  logic [31:0] rel_tgt;
  logic [31:0] next_pc;
  logic        taken;

  assign {fz, fc, fs, fv} = flags;

  assign npc      = pc + 32'd4;
  assign off_sext = {{(32-OFF_W){br_offset[OFF_W-1]}}, br_offset};
  assign rel_tgt  = npc + off_sext;

  // Conditional branches see only flags latched by earlier instructions.
  always_comb begin
    taken   = 1'b0;
    next_pc = npc;
    unique case (1'b1)
      (br_type == BR_B),
      (br_type == BR_BL):   taken = 1'b1;
      (br_type == BR_BZ):   taken = fz;
      (br_type == BR_BNZ):  taken = !fz;
      (br_type == BR_BCY):  taken = fc;
      (br_type == BR_BNCY): taken = !fc;
      (br_type == BR_BLTZ): taken = fs;
      (br_type == BR_BOV):  taken = fv;
      default:              taken = 1'b0;
    endcase
    if (br_type == BR_JR) begin
      next_pc = jr_target;
    end else if (taken) begin
      next_pc = rel_tgt;
    end
    next_pc[1:0] = 2'b00;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   state_nxt = FETCH;
      FETCH:  if (imem_ack) state_nxt = EXEC;
      EXEC:   if (exec_done) state_nxt = halt ? HALTED : FETCH;
      HALTED: state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= 32'd0;
      flags <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && imem_ack) begin
        instr <= imem_rdata;
      end
      if (state == EXEC && exec_done) begin
        pc <= next_pc;
        if (flag_we) begin
          flags <= {zero_flag, carry_flag, sign_flag, overflow_flag};
        end
      end
    end
  end

  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == EXEC);
  assign halted      = (state == HALTED);

endmodule
